// File: rtl/halut_result_collector.sv
// Result collector for the HALUT decoder-array stream.
// Tracks decoder index order, tags row ends, buffers in a FWFT FIFO.
module halut_result_collector #(
    parameter int DecoderUnits = 16,
    parameter int FifoDepth    = 32,
    parameter int DecAddrWidth = $clog2(DecoderUnits),
    parameter int CntWidth     = $clog2(FifoDepth) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             result_i,
    input  logic                    valid_i,
    input  logic [DecAddrWidth-1:0] m_addr_i,
    input  logic                    clear_i,
    output logic [31:0]             out_data_o,
    output logic [DecAddrWidth-1:0] out_m_addr_o,
    output logic                    out_last_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CntWidth-1:0]     count_o,
    output logic                    overflow_o,
    output logic                    seq_err_o,
    output logic [15:0]             rows_o
);

    localparam int PtrWidth   = $clog2(FifoDepth);
    localparam int EntryWidth = 1 + DecAddrWidth + 32;

    localparam logic [DecAddrWidth-1:0] LastAddr  = DecAddrWidth'(DecoderUnits - 1);
    localparam logic [CntWidth-1:0]     FullCount = CntWidth'(FifoDepth);

    logic [EntryWidth-1:0]   r_mem [FifoDepth];
    logic [PtrWidth-1:0]     r_wr_ptr;
    logic [PtrWidth-1:0]     r_rd_ptr;
    logic [CntWidth-1:0]     r_count;
    logic [DecAddrWidth-1:0] r_exp;
    logic                    r_overflow;
    logic                    r_seq_err;
    logic [15:0]             r_rows;

    logic [EntryWidth-1:0]   w_head;
    logic [EntryWidth-1:0]   w_entry;
    logic                    w_head_valid;
    logic                    w_head_last;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_entry = {(m_addr_i == LastAddr), m_addr_i, result_i};

    // Handshake decode: clear suppresses both push and pop; a pop frees a slot
    always_comb begin
        w_head_valid = (r_count != '0);
        w_head_last  = w_head_valid && w_head[EntryWidth-1];
        w_full       = (r_count == FullCount);
        w_pop        = w_head_valid && out_ready_i && !clear_i;
        w_push       = valid_i && !clear_i && (!w_full || w_pop);
        w_drop       = valid_i && !clear_i && !w_push;
    end

    // Storage array; contents are only observed through the count-qualified head
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Index tracker mirroring the producer's gather counter, plus sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exp     <= '0;
            r_seq_err <= 1'b0;
        end else if (clear_i) begin
            r_exp     <= '0;
            r_seq_err <= 1'b0;
        end else if (!valid_i) begin
            r_exp <= '0;
        end else if (m_addr_i == r_exp) begin
            r_exp <= r_exp + DecAddrWidth'(1);
        end else begin
            r_exp     <= m_addr_i + DecAddrWidth'(1);
            r_seq_err <= 1'b1;
        end
    end

    // Sticky overflow and saturating completed-row counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_rows     <= '0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
            r_rows     <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && w_head_last && (r_rows != 16'hFFFF)) begin
                r_rows <= r_rows + 16'd1;
            end
        end
    end

    assign out_valid_o  = w_head_valid;
    assign out_last_o   = w_head_last;
    assign out_data_o   = w_head_valid ? w_head[31:0] : '0;
    assign out_m_addr_o = w_head_valid ? w_head[32 +: DecAddrWidth] : '0;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;
    assign seq_err_o    = r_seq_err;
    assign rows_o       = r_rows;

endmodule
